// File: rtl/rect_draw_scheduler_pkg.sv
// rect_draw_scheduler_pkg: shared state encoding, default widths and draw length for the rectangle scheduler.
package rect_draw_scheduler_pkg;
    localparam int DEF_COORD_W     = 7;
    localparam int DEF_COLOR_W     = 3;
    localparam int DEF_DRAW_CYCLES = 16;
    localparam int DEF_WATCHDOG    = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_DRAW,
        S_DONE
    } state_t;
endpackage

// File: rtl/rect_draw_scheduler_if.sv
// rect_draw_scheduler_if: two-requester valid/ready draw request bus.
interface rect_draw_scheduler_if #(
    parameter int COORD_W = 7,
    parameter int COLOR_W = 3
);
    logic               req0_valid;
    logic [COORD_W-1:0] req0_x;
    logic [COORD_W-1:0] req0_y;
    logic [COLOR_W-1:0] req0_color;
    logic               req0_ready;
    logic               req1_valid;
    logic [COORD_W-1:0] req1_x;
    logic [COORD_W-1:0] req1_y;
    logic [COLOR_W-1:0] req1_color;
    logic               req1_ready;

    modport master (
        output req0_valid, req0_x, req0_y, req0_color,
        output req1_valid, req1_x, req1_y, req1_color,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_color,
        input  req1_valid, req1_x, req1_y, req1_color,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/rect_draw_scheduler_arbiter.sv
// rect_req_arbiter: picks one of two requesters; ROUND_ROBIN_EN selects alternating priority, else requester 0 always wins.
module rect_req_arbiter (
`ifdef ROUND_ROBIN_EN
    input  logic last,
`endif
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic gnt,
    output logic ready0,
    output logic ready1
);
`ifdef ROUND_ROBIN_EN
    assign gnt = (valid0 && valid1) ? ~last : valid1;
`else
    assign gnt = ~valid0 && valid1;
`endif
    assign ready0 = en && valid0 && !gnt;
    assign ready1 = en && valid1 && gnt;
endmodule

// File: rtl/rect_draw_scheduler.sv
// rect_draw_scheduler: arbitrates draw requests and sequences the 4x4 rectangle datapath.
// Optional ROUND_ROBIN_EN macro builds a last-grant pointer for alternating arbitration.
module rect_draw_scheduler
    import rect_draw_scheduler_pkg::*;
#(
    parameter int COORD_W     = DEF_COORD_W,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int DRAW_CYCLES = DEF_DRAW_CYCLES,
    parameter int WATCHDOG    = DEF_WATCHDOG
) (
    input  logic               clk,
    input  logic               resetn,
    rect_draw_scheduler_if.slave req,
    output logic [COORD_W-1:0] dp_data_in,
    output logic               dp_ld_x,
    output logic               dp_ld_y,
    output logic               dp_start_count,
    input  logic               dp_write_en,
    output logic [COLOR_W-1:0] colour,
    output logic               busy,
    output logic               grant_id,
    output logic               done,
    output logic               abort_err
);
    localparam int WR_W = $clog2(DRAW_CYCLES + 1);
    localparam int WD_W = $clog2(WATCHDOG + 1);

    state_t             state, nxt;
    logic [COORD_W-1:0] x_q, y_q;
    logic [COLOR_W-1:0] col_q;
    logic               gid_q, abort_q;
    logic [WR_W-1:0]    wr_cnt, wr_nxt;
    logic [WD_W-1:0]    wd_cnt, wd_nxt;
    logic               hs, gnt, wr_full, wd_full, in_draw;

`ifdef ROUND_ROBIN_EN
    logic last_q;
    // Reset to "1 granted last" so requester 0 has first priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_q <= 1'b1;
        else if (hs) last_q <= gnt;
    end
`endif

    // Ready is masked during reset so every output reads 0 while resetn is low.
    rect_req_arbiter u_arb (
`ifdef ROUND_ROBIN_EN
        .last   (last_q),
`endif
        .en     (state == S_IDLE && resetn),
        .valid0 (req.req0_valid),
        .valid1 (req.req1_valid),
        .gnt    (gnt),
        .ready0 (req.req0_ready),
        .ready1 (req.req1_ready)
    );

    assign hs      = req.req0_ready || req.req1_ready;
    assign in_draw = state == S_DRAW;
    assign wr_nxt  = wr_cnt + WR_W'(dp_write_en);
    assign wd_nxt  = wd_cnt + WD_W'(1);
    assign wr_full = wr_nxt == WR_W'(DRAW_CYCLES);
    assign wd_full = wd_nxt == WD_W'(WATCHDOG);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            gid_q   <= 1'b0;
            abort_q <= 1'b0;
            wr_cnt  <= '0;
            wd_cnt  <= '0;
        end else begin
            state <= nxt;
            if (hs) begin
                x_q   <= gnt ? req.req1_x : req.req0_x;
                y_q   <= gnt ? req.req1_y : req.req0_y;
                col_q <= gnt ? req.req1_color : req.req0_color;
                gid_q <= gnt;
            end
            // Counters only run inside DRAW, so they are clear on every DRAW entry.
            wr_cnt <= in_draw ? wr_nxt : '0;
            wd_cnt <= in_draw ? wd_nxt : '0;
            if (in_draw && wd_full && !wr_full) abort_q <= 1'b1;
        end
    end

    always_comb begin
        nxt            = state;
        dp_data_in     = '0;
        dp_ld_x        = 1'b0;
        dp_ld_y        = 1'b0;
        dp_start_count = 1'b0;
        done           = 1'b0;
        case (state)
            S_IDLE:   nxt = hs ? S_LOAD_X : S_IDLE;
            S_LOAD_X: begin
                nxt        = S_LOAD_Y;
                dp_data_in = x_q;
                dp_ld_x    = 1'b1;
            end
            S_LOAD_Y: begin
                nxt        = S_DRAW;
                dp_data_in = y_q;
                dp_ld_y    = 1'b1;
            end
            S_DRAW: begin
                dp_start_count = 1'b1;
                nxt            = (wr_full || wd_full) ? S_DONE : S_DRAW;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign busy      = state != S_IDLE;
    assign colour    = busy ? col_q : '0;
    assign grant_id  = gid_q;
    assign abort_err = abort_q;
endmodule

// File: tb/tb_rect_draw_scheduler.sv
// tb_rect_draw_scheduler: arbitration vectors, directed draw sequences and random traffic
// checked every cycle against a handshake-timeline reference model.
module tb_rect_draw_scheduler;
    import rect_draw_scheduler_pkg::*;

    localparam int CW = DEF_COORD_W;
    localparam int KW = DEF_COLOR_W;
    localparam int NW = DEF_DRAW_CYCLES;
    localparam int WD = DEF_WATCHDOG;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          dp_we;
    logic [CW-1:0] data;
    logic          ldx, ldy, sc, busy, gid, done, abort_err;
    logic [KW-1:0] colour;

    rect_draw_scheduler_if #(.COORD_W(CW), .COLOR_W(KW)) rq ();

    rect_draw_scheduler dut (
        .clk            (clk),
        .resetn         (resetn),
        .req            (rq),
        .dp_data_in     (data),
        .dp_ld_x        (ldx),
        .dp_ld_y        (ldy),
        .dp_start_count (sc),
        .dp_write_en    (dp_we),
        .colour         (colour),
        .busy           (busy),
        .grant_id       (gid),
        .done           (done),
        .abort_err      (abort_err)
    );

    always #5 clk = ~clk;

    // Stimulus variables, copied onto the bus at each falling edge.
    logic          v0 = 1'b0, v1 = 1'b0, we = 1'b0;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [KW-1:0] c0 = '0, c1 = '0;

    // Reference model: a draw is a timeline relative to its handshake cycle t_hs.
    int            n = 0, t_hs = -1, t_done = -1, writes = 0, k_now = -1;
    bit            m_last = 1'b1, m_gid = 1'b0, m_abort = 1'b0, hs_now = 1'b0;
    logic [CW-1:0] m_x = '0, m_y = '0;
    logic [KW-1:0] m_col = '0;

    int n_cmp = 0, n_bad = 0;

    typedef struct packed {
        logic v0, v1, r0, r1;
    } arb_vec_t;
    arb_vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({rq.req0_ready, rq.req1_ready, data, ldx, ldy, sc, colour, busy, gid, done, abort_err});
    endfunction

    task automatic drive();
        rq.req0_valid = v0; rq.req0_x = x0; rq.req0_y = y0; rq.req0_color = c0;
        rq.req1_valid = v1; rq.req1_x = x1; rq.req1_y = y1; rq.req1_color = c1;
        dp_we = we;
    endtask

    task automatic step(input string tag);
        bit r0, r1, lx, ly, s, b, d, win;
        logic [CW-1:0] dt;
        logic [KW-1:0] co;
        @(negedge clk);
        drive();
        #1;
        r0 = 0; r1 = 0; lx = 0; ly = 0; s = 0; b = 0; d = 0; dt = '0; co = '0;
        k_now = (t_hs < 0) ? -1 : n - t_hs;
`ifdef ROUND_ROBIN_EN
        win = (v0 && v1) ? !m_last : v1;
`else
        win = !v0 && v1;
`endif
        if (t_hs < 0) begin
            r0 = (v0 || v1) && !win;
            r1 = (v0 || v1) && win;
        end else begin
            b  = 1;
            co = m_col;
            if (k_now == 1) begin lx = 1; dt = m_x; end
            else if (k_now == 2) begin ly = 1; dt = m_y; end
            else if (n == t_done) d = 1;
            else s = 1;
        end
        chk(tag, outs(), 32'({r0, r1, dt, lx, ly, s, co, b, m_gid, d, m_abort}));
        hs_now = 0;
        if (t_hs < 0) begin
            if (v0 || v1) begin
                hs_now = 1; t_hs = n; t_done = -1; writes = 0;
                m_gid = win; m_last = win;
                m_x = win ? x1 : x0; m_y = win ? y1 : y0; m_col = win ? c1 : c0;
            end
        end else if (n == t_done) begin
            t_hs = -1;
        end else if (k_now >= 3) begin
            writes += int'(we);
            if (writes == NW) t_done = n + 1;
            else if (k_now - 2 == WD) begin t_done = n + 1; m_abort = 1; end
        end
        n++;
    endtask

    task automatic reset_dut();
        #2;
        resetn = 1'b0;
        drive();
        #1;
        chk("rst_outputs", outs(), 32'd0);
        t_hs = -1; t_done = -1; m_gid = 0; m_abort = 0; m_last = 1;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 150 && t_hs >= 0; c++) step(tag);
    endtask

    int  dk, wr_seen, ng;
    bit  col_ok, r1_seen, prev_hs;
    int  grants [3];
    int  exp_g [3];

    initial begin
        tbl = '{4'b0000, 4'b1010, 4'b0101, 4'b1110};
`ifdef ROUND_ROBIN_EN
        exp_g = '{0, 1, 0};
`else
        exp_g = '{0, 0, 0};
`endif
        drive();
        reset_dut();

        // Combinational arbitration in IDLE; valids withdrawn before the next rising edge.
        @(negedge clk);
        foreach (tbl[i]) begin
            rq.req0_valid = tbl[i].v0;
            rq.req1_valid = tbl[i].v1;
            #1;
            chk($sformatf("arb_tbl%0d", i), 32'({rq.req0_ready, rq.req1_ready, busy}),
                32'({tbl[i].r0, tbl[i].r1, 1'b0}));
        end
        rq.req0_valid = 1'b0;
        rq.req1_valid = 1'b0;

        // Single request with an ideal datapath.
        v0 = 1; x0 = 7'd10; y0 = 7'd20; c0 = 3'd5; we = 1;
        step("single_hs");
        v0 = 0;
        col_ok = 1; wr_seen = 0; dk = -1;
        for (int k = 1; k <= 20; k++) begin
            step("single");
            if (k == 1) chk("single_ldx", 32'({ldx, data}), 32'({1'b1, 7'd10}));
            if (k == 2) chk("single_ldy", 32'({ldy, data}), 32'({1'b1, 7'd20}));
            if (k <= 19 && colour !== 3'd5) col_ok = 0;
            if (sc && we) wr_seen++;
            if (done && dk < 0) dk = k;
        end
        chk("single_colour", 32'(col_ok), 32'd1);
        chk("single_writes", 32'(wr_seen), 32'd16);
        chk("single_done_at", 32'(dk), 32'd19);
        chk("single_busy_T20", 32'(busy), 32'd0);

        // Sustained contention for three draws.
        reset_dut();
        v0 = 1; v1 = 1; x0 = 7'd1; y0 = 7'd2; c0 = 3'd3; x1 = 7'd4; y1 = 7'd5; c1 = 3'd6;
        r1_seen = 0; prev_hs = 0; ng = 0;
        for (int c = 0; c < 200 && ng < 3; c++) begin
            step("contend");
            if (rq.req1_ready) r1_seen = 1;
            if (prev_hs) begin grants[ng] = int'(gid); ng++; end
            prev_hs = hs_now;
        end
        v0 = 0; v1 = 0;
        wait_idle("contend_drain");
        chk("contend_count", 32'(ng), 32'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("contend_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
`ifdef ROUND_ROBIN_EN
        chk("contend_r1_ready", 32'(r1_seen), 32'd1);
`else
        chk("contend_r1_ready", 32'(r1_seen), 32'd0);
`endif

        // Stalled datapath trips the watchdog; abort_err then survives a good draw.
        we = 0; v0 = 1; x0 = 7'd99; y0 = 7'd3; c0 = 3'd2;
        step("stall_hs");
        v0 = 0; dk = -1;
        for (int k = 1; k <= 80 && dk < 0; k++) begin
            step("stall");
            if (done) dk = k;
        end
        chk("stall_done_at", 32'(dk), 32'(3 + WD));
        step("stall_after");
        chk("stall_abort", 32'(abort_err), 32'd1);
        we = 1; v1 = 1; x1 = 7'd50; y1 = 7'd60; c1 = 3'd7;
        step("post_hs");
        v1 = 0; dk = -1;
        for (int k = 1; k <= 40 && dk < 0; k++) begin
            step("post");
            if (done) dk = k;
        end
        chk("post_done_at", 32'(dk), 32'(3 + NW));
        chk("post_abort_sticky", 32'(abort_err), 32'd1);
        wait_idle("post_drain");

        // One-on/one-off write strobes: 16th strobe lands 31 cycles into DRAW.
        reset_dut();
        v0 = 1; x0 = 7'd17; y0 = 7'd34; c0 = 3'd1;
        step("gap_hs");
        v0 = 0; dk = -1;
        for (int k = 1; k <= 60 && dk < 0; k++) begin
            we = (k % 2) == 1;
            step("gap");
            if (done) dk = k;
        end
        chk("gap_done_at", 32'(dk), 32'd34);
        chk("gap_abort", 32'(abort_err), 32'd0);
        we = 1;
        wait_idle("gap_drain");

        // Reset at draw cycle 5 with requester 1 waiting.
        v0 = 1; x0 = 7'd5; y0 = 7'd6; c0 = 3'd4;
        step("rst_hs");
        v0 = 0;
        for (int k = 1; k <= 7; k++) step("rst_draw");
        v1 = 1; x1 = 7'd77; y1 = 7'd88; c1 = 3'd3;
        reset_dut();
        step("rst_first_idle");
        chk("rst_req1_ready", 32'(rq.req1_ready), 32'd1);
        v1 = 0;
        step("rst_gid");
        chk("rst_gid_ldx", 32'({gid, ldx, data}), 32'({1'b1, 1'b1, 7'd77}));
        wait_idle("rst_drain");

        // Random traffic, with a stalled-datapath window every fourth block.
        for (int c = 0; c < 3000; c++) begin
            if (!v0 && $urandom_range(0, 3) == 0) begin
                v0 = 1; x0 = CW'($urandom); y0 = CW'($urandom); c0 = KW'($urandom);
            end else if (v0 && $urandom_range(0, 29) == 0) v0 = 0;
            if (!v1 && $urandom_range(0, 3) == 0) begin
                v1 = 1; x1 = CW'($urandom); y1 = CW'($urandom); c1 = KW'($urandom);
            end else if (v1 && $urandom_range(0, 29) == 0) v1 = 0;
            we = ((c / 300) % 4 == 3) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) != 0);
            step("rand");
            if (hs_now && !m_gid) v0 = 0;
            if (hs_now && m_gid) v1 = 0;
        end
        v0 = 0; v1 = 0; we = 1;
        wait_idle("rand_drain");
        step("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
